// File: rtl/shifter_pkg.sv
// shifter_pkg: shared FSM state, mode and default width constants for the shift datapath
package shifter_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;
  localparam logic MODE_ROL = 1'b0;
  localparam logic MODE_SHL = 1'b1;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_AMT_W = 4;
endpackage

// File: rtl/rotl1_step.sv
// rotl1_step: one-position rotate-left or logical shift-left with the MSB as carry-out
module rotl1_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] data_o,
  output logic             carry_o
);
  assign data_o  = {data_i[WIDTH-2:0], (mode_i == MODE_SHL) ? 1'b0 : data_i[WIDTH-1]};
  assign carry_o = data_i[WIDTH-1];
endmodule

// File: rtl/serial_rotate_left_16.sv
// serial_rotate_left_16: bit-serial ROL/SHL, one position per clock, valid/ready on both sides
module serial_rotate_left_16
  import shifter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d, step_data;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d, carry_q, carry_d, step_carry;

  rotl1_step #(.WIDTH(WIDTH)) u_step (
    .data_i (data_q),
    .mode_i (mode_q),
    .data_o (step_data),
    .carry_o(step_carry)
  );

  // next state: latch on accept, step while counting down, release on output handshake
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    if (state_q == IDLE && in_valid) begin
      data_d  = in_data;
      mode_d  = in_mode;
      cnt_d   = in_amt;
      carry_d = 1'b0;
      state_d = (in_amt == '0) ? DONE : SHIFT;
    end else if (state_q == SHIFT) begin
      data_d  = step_data;
      carry_d = step_carry;
      cnt_d   = cnt_q - 1'b1;
      state_d = (cnt_q == AMT_W'(1)) ? DONE : SHIFT;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end

  // state registers; reset drops any in-flight request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_ROL;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign out_carry = carry_q;
endmodule

// File: tb/tb_serial_rotate_left_16.sv
// tb_serial_rotate_left_16: directed and randomized checks against an arithmetic reference model
module tb_serial_rotate_left_16;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_mode, out_valid, out_ready, out_carry;
  logic [15:0] in_data, out_data;
  logic [3:0]  in_amt;
  int          total = 0;
  int          bad = 0;

  serial_rotate_left_16 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_amt   (in_amt),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_carry(out_carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [15:0] d, input int a, input logic m,
                                output logic [15:0] r, output logic c);
    logic [31:0] t;
    t = {d, d} << a;
    r = m ? t[15:0] : t[31:16];
    c = (a == 0) ? 1'b0 : (m ? d[16-a] : r[0]);
  endfunction

  function automatic logic [15:0] rotr(input logic [15:0] x, input int a);
    logic [31:0] t;
    t = {x, x} >> a;
    return t[15:0];
  endfunction

  task automatic xfer(input logic [15:0] d, input int a, input logic m, input int stall,
                      input string tag);
    logic [15:0] er;
    logic        ec;
    int          n;
    model(d, a, m, er, ec);
    @(negedge clk);
    chk({tag, ".in_ready"}, in_ready, 1);
    in_valid  = 1'b1;
    in_data   = d;
    in_amt    = a[3:0];
    in_mode   = m;
    out_ready = 1'($urandom);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_amt   = 4'($urandom);
    in_mode  = 1'($urandom);
    n = 1;
    while (!out_valid && n < 40) begin
      out_ready = 1'($urandom);
      @(negedge clk);
      n++;
    end
    out_ready = (stall == 0);
    chk({tag, ".lat"}, n, a + 1);
    chk({tag, ".data"}, out_data, er);
    chk({tag, ".carry"}, out_carry, ec);
    if (!m) chk({tag, ".rotr"}, rotr(out_data, a), d);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, ".hold_data"}, out_data, er);
      chk({tag, ".hold_rdy"}, {out_valid, in_ready}, 2'b10);
      in_valid = 1'($urandom);
      in_data  = 16'($urandom);
      in_amt   = 4'($urandom);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".drain"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_mode   = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("reset", {in_ready, out_valid, out_data, out_carry}, {1'b1, 1'b0, 16'h0, 1'b0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    xfer(16'h4123, 4, 1'b0, 0, "rol4");
    xfer(16'h8001, 1, 1'b1, 0, "shl1");
    xfer(16'hFFFF, 15, 1'b1, 1, "shl15");
    xfer(16'hBEEF, 0, 1'b0, 0, "amt0_rol");
    xfer(16'hBEEF, 0, 1'b1, 2, "amt0_shl");
    xfer(16'h0001, 15, 1'b0, 0, "rol15");
    xfer(16'h8001, 4, 1'b0, 5, "bp");

    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h00FF;
    in_amt   = 4'd8;
    in_mode  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset", {in_ready, out_valid, out_data, out_carry}, {1'b1, 1'b0, 16'h0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    xfer(16'h0F0F, 4, 1'b0, 0, "post_rst");

    for (int k = 0; k < 1000; k++)
      xfer(16'($urandom), int'($urandom_range(0, 15)), 1'($urandom),
           int'($urandom_range(0, 3)), "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
